// File: rtl/vga_rx_timing_if.sv
// VGA receive bundle: raw sync/pixel inputs plus rebuilt coordinates and geometry.
// FRAME_CHKSUM_EN adds the frame_sum signal.
interface vga_rx_timing_if;
  localparam int unsigned CW = 12;
  localparam int unsigned PW = 10;
  localparam int unsigned DW = 24;

  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_BLK;
  logic [DW-1:0] VGA_RGB;
  logic          pix_valid;
  logic [PW-1:0] pix_x;
  logic [PW-1:0] pix_y;
  logic [DW-1:0] pix_data;
  logic          frame_start;
  logic [CW-1:0] h_total;
  logic [CW-1:0] h_active;
  logic [CW-1:0] v_total;
  logic [CW-1:0] v_active;
  logic          locked;
  logic          err;
`ifdef FRAME_CHKSUM_EN
  logic [31:0]   frame_sum;
`endif

  modport master (
`ifdef FRAME_CHKSUM_EN
    input  frame_sum,
`endif
    output VGA_HS, VGA_VS, VGA_BLK, VGA_RGB,
    input  pix_valid, pix_x, pix_y, pix_data, frame_start,
    input  h_total, h_active, v_total, v_active, locked, err
  );

  modport slave (
`ifdef FRAME_CHKSUM_EN
    output frame_sum,
`endif
    input  VGA_HS, VGA_VS, VGA_BLK, VGA_RGB,
    output pix_valid, pix_x, pix_y, pix_data, frame_start,
    output h_total, h_active, v_total, v_active, locked, err
  );
endinterface

// File: rtl/vga_rx_timing.sv
// VGA receiver: rebuilds pixel coordinates, measures line/frame geometry and reports lock.
// FRAME_CHKSUM_EN: adds a per-frame RGB sum (frame_sum) that also takes part in the lock check.
module vga_rx_timing #(
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic           Clk25M,
  input  logic           Rst_n,
  vga_rx_timing_if.slave vga
);

  localparam int unsigned CW = 12;
  localparam int unsigned PW = 10;
  localparam int unsigned DW = 24;
  localparam int unsigned MW = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);

  logic          hs_q, vs_q, blk_q;
  logic [DW-1:0] rgb_q;
  logic          hs_act_p_q, vs_act_p_q, blk_p_q;
  logic          hs_act, vs_act, hs_lead, vs_lead, blk_rise;

  // Sync registers reset to the inactive level so release does not fake an edge
  always_ff @(posedge Clk25M or negedge Rst_n) begin
    if (!Rst_n) begin
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      blk_q      <= 1'b0;
      rgb_q      <= '0;
      hs_act_p_q <= 1'b0;
      vs_act_p_q <= 1'b0;
      blk_p_q    <= 1'b0;
    end else begin
      hs_q       <= vga.VGA_HS;
      vs_q       <= vga.VGA_VS;
      blk_q      <= vga.VGA_BLK;
      rgb_q      <= vga.VGA_RGB;
      hs_act_p_q <= hs_act;
      vs_act_p_q <= vs_act;
      blk_p_q    <= blk_q;
    end
  end

  assign hs_act   = (hs_q == SYNC_POL);
  assign vs_act   = (vs_q == SYNC_POL);
  assign hs_lead  = hs_act & ~hs_act_p_q;
  assign vs_lead  = vs_act & ~vs_act_p_q;
  assign blk_rise = blk_q & ~blk_p_q;

  logic          pix_valid_q, frame_start_q, new_frame_q;
  logic [PW-1:0] pix_x_q, pix_y_q;
  logic [DW-1:0] pix_data_q;
  logic          first_line;

  assign first_line = new_frame_q | vs_lead;

  // Pixel path, independent of the lock FSM
  always_ff @(posedge Clk25M or negedge Rst_n) begin
    if (!Rst_n) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      new_frame_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
    end else begin
      pix_valid_q   <= blk_q;
      frame_start_q <= blk_rise & first_line;
      if (blk_q) pix_data_q <= rgb_q;
      if (blk_rise)   pix_x_q <= '0;
      else if (blk_q) pix_x_q <= pix_x_q + PW'(1);
      if (blk_rise)   pix_y_q <= first_line ? '0 : pix_y_q + PW'(1);
      if (blk_rise)     new_frame_q <= 1'b0;
      else if (vs_lead) new_frame_q <= 1'b1;
    end
  end

  logic [CW-1:0] h_cnt_q, act_cnt_q, line_len_q, last_act_q, line_cnt_q, act_lines_q;
  logic          frame_bad_q;
  logic [CW-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic [1:0]    state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic          err_q, err_d, locked_q, latch;

  logic [CW-1:0] h_inc, line_act_cur, line_len_now, last_act_now, f_vtot, f_vact;
  logic          line_has, line_bad, checking, frame_bad_now, geom_ok, to_hit, sum_ok;

`ifdef FRAME_CHKSUM_EN
  localparam int unsigned SW = 32;
  logic [SW-1:0] sum_acc_q, frame_sum_q, sum_now;

  assign sum_now = sum_acc_q + (blk_q ? SW'(rgb_q) : '0);
  assign sum_ok  = (sum_now == frame_sum_q);

  // Running sum closes into frame_sum on every frame boundary
  always_ff @(posedge Clk25M or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_acc_q   <= '0;
      frame_sum_q <= '0;
    end else if (vs_lead) begin
      sum_acc_q   <= '0;
      frame_sum_q <= sum_now;
    end else begin
      sum_acc_q   <= sum_now;
    end
  end

  assign vga.frame_sum = frame_sum_q;
`else
  assign sum_ok = 1'b1;
`endif

  // Line/frame measurement; a same-clock HS edge is folded into the closing frame
  always_comb begin
    h_inc         = (h_cnt_q == CNT_SAT) ? CNT_SAT : h_cnt_q + CW'(1);
    line_act_cur  = act_cnt_q + CW'(blk_q);
    line_has      = (line_act_cur != '0);
    line_len_now  = hs_lead ? h_inc : line_len_q;
    last_act_now  = (hs_lead && line_has) ? line_act_cur : last_act_q;
    f_vtot        = line_cnt_q + CW'(hs_lead);
    f_vact        = act_lines_q + CW'(hs_lead && line_has);
    line_bad      = hs_lead && ((h_inc != h_total_q) ||
                                (line_has && (line_act_cur != h_active_q)));
    checking      = (state_q == S_CHECK) || (state_q == S_LOCKED);
    frame_bad_now = frame_bad_q || (checking && line_bad);
    geom_ok       = !frame_bad_now && (line_len_now == h_total_q) &&
                    (last_act_now == h_active_q) && (f_vtot == v_total_q) &&
                    (f_vact == v_active_q) && sum_ok;
    to_hit        = !hs_lead && (h_inc == TO_VAL) && (h_cnt_q != TO_VAL);
  end

  always_ff @(posedge Clk25M or negedge Rst_n) begin
    if (!Rst_n) begin
      h_cnt_q     <= '0;
      act_cnt_q   <= '0;
      line_len_q  <= '0;
      last_act_q  <= '0;
      line_cnt_q  <= '0;
      act_lines_q <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      if (hs_lead) begin
        h_cnt_q    <= '0;
        act_cnt_q  <= '0;
        line_len_q <= h_inc;
        last_act_q <= last_act_now;
      end else begin
        h_cnt_q    <= h_inc;
        act_cnt_q  <= line_act_cur;
      end
      line_cnt_q  <= vs_lead ? '0 : f_vtot;
      act_lines_q <= vs_lead ? '0 : f_vact;
      frame_bad_q <= (vs_lead || to_hit) ? 1'b0 : frame_bad_now;
    end
  end

  // Lock FSM: timeout dominates, everything else is decided at VS leading edges
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    if (to_hit) begin
      state_d = S_IDLE;
      match_d = '0;
      err_d   = 1'b1;
    end else if (vs_lead) begin
      case (state_q)
        S_IDLE: state_d = S_MEASURE;
        S_MEASURE: begin
          latch   = 1'b1;
          match_d = MW'(1);
          state_d = (LOCK_N <= MW'(1)) ? S_LOCKED : S_CHECK;
        end
        S_CHECK: begin
          if (geom_ok) begin
            match_d = match_q + MW'(1);
            if (match_d >= LOCK_N) state_d = S_LOCKED;
          end else begin
            err_d   = 1'b1;
            latch   = 1'b1;
            match_d = MW'(1);
          end
        end
        S_LOCKED: begin
          if (!geom_ok) begin
            err_d   = 1'b1;
            latch   = 1'b1;
            match_d = MW'(1);
            state_d = S_CHECK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk25M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      match_q    <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      h_total_q  <= '0;
      h_active_q <= '0;
      v_total_q  <= '0;
      v_active_q <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      err_q    <= err_d;
      locked_q <= (state_d == S_LOCKED);
      if (latch) begin
        h_total_q  <= line_len_now;
        h_active_q <= last_act_now;
        v_total_q  <= f_vtot;
        v_active_q <= f_vact;
      end
    end
  end

  assign vga.pix_valid   = pix_valid_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.pix_data    = pix_data_q;
  assign vga.frame_start = frame_start_q;
  assign vga.h_total     = h_total_q;
  assign vga.h_active    = h_active_q;
  assign vga.v_total     = v_total_q;
  assign vga.v_active    = v_active_q;
  assign vga.locked      = locked_q;
  assign vga.err         = err_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing on a shrunken raster: 20 clocks x 10 lines,
// 12x6 active, active-low syncs, HS and VS leading edges on the same clock.
module tb_vga_rx_timing;

  localparam int unsigned LINE_CLKS = 20;
  localparam int unsigned FRM_LINES = 10;
  localparam int unsigned EXP_HT    = 20;
  localparam int unsigned EXP_HA    = 12;
  localparam int unsigned EXP_VT    = 10;
  localparam int unsigned EXP_VA    = 6;
  localparam int unsigned EXP_PIX   = 72;
  localparam int unsigned EXP_LAST  = 2321;   // line 9, col 17 -> 9*256+17
  localparam int unsigned EXP_FIRST = 1030;   // line 4, col 6  -> 4*256+6

  logic clk = 1'b0;
  logic rst_n;

  vga_rx_timing_if bus ();

  vga_rx_timing dut (
    .Clk25M (clk),
    .Rst_n  (rst_n),
    .vga    (bus)
  );

  always #20 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int unsigned cyc = 0, since_rst = 0;
  int unsigned pv_cnt = 0, fs_cnt = 0, fs_bad = 0, err_cnt = 0, err_cyc = 0, lat_bad = 0;
  logic [9:0]  last_x = '0, last_y = '0;
  logic [23:0] last_data = '0, fs_data = '0;
  logic        blk_h1 = 1'b0, blk_h2 = 1'b0;
  logic [23:0] rgb_h1 = '0, rgb_h2 = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) since_rst = 0;
    else if (since_rst < 8) since_rst++;
    if (since_rst >= 3) begin
      if ((bus.pix_valid !== blk_h2) || (blk_h2 && (bus.pix_data !== rgb_h2))) lat_bad++;
    end
    if (bus.pix_valid) begin
      pv_cnt++;
      last_x    = bus.pix_x;
      last_y    = bus.pix_y;
      last_data = bus.pix_data;
    end
    if (bus.frame_start) begin
      fs_cnt++;
      fs_data = bus.pix_data;
      if (!bus.pix_valid || bus.pix_x != 10'd0 || bus.pix_y != 10'd0) fs_bad++;
    end
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    blk_h2 = blk_h1;
    rgb_h2 = rgb_h1;
    blk_h1 = bus.VGA_BLK;
    rgb_h1 = bus.VGA_RGB;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int l, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      bus.VGA_HS  = (c < 3) ? 1'b0 : 1'b1;
      bus.VGA_VS  = (l < 2) ? 1'b0 : 1'b1;
      bus.VGA_BLK = (l >= 4) && (c >= 6) && (c < 18);
      bus.VGA_RGB = 24'(l * 256 + c);
      tick();
    end
  endtask

  task automatic run_frame(input int stretch);
    for (int l = 0; l < int'(FRM_LINES); l++)
      run_line(l, 0, (l == stretch) ? int'(LINE_CLKS) + 1 : int'(LINE_CLKS));
  endtask

  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.VGA_HS  = 1'b1;
      bus.VGA_VS  = 1'b1;
      bus.VGA_BLK = 1'b0;
      bus.VGA_RGB = '0;
      tick();
    end
  endtask

  int unsigned pv0, fs0, err0, hold_start;

  initial begin
    rst_n       = 1'b0;
    bus.VGA_HS  = 1'b1;
    bus.VGA_VS  = 1'b1;
    bus.VGA_BLK = 1'b0;
    bus.VGA_RGB = '0;
    repeat (3) tick();
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_pix_x", 32'(bus.pix_x), 0);
    chk("rst_frame_start", 32'(bus.frame_start), 0);
    chk("rst_h_total", 32'(bus.h_total), 0);
    chk("rst_v_total", 32'(bus.v_total), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;

    // Measure frame then first compare frame
    run_frame(-1);
    run_frame(-1);
    chk("lat_h_total", 32'(bus.h_total), EXP_HT);
    chk("lat_h_active", 32'(bus.h_active), EXP_HA);
    chk("lat_v_total", 32'(bus.v_total), EXP_VT);
    chk("lat_v_active", 32'(bus.v_active), EXP_VA);
    chk("not_yet_locked", 32'(bus.locked), 0);

    pv0 = pv_cnt;
    fs0 = fs_cnt;
    run_frame(-1);
    chk("locked_after_2", 32'(bus.locked), 1);
    chk("pix_per_frame", pv_cnt - pv0, EXP_PIX);
    chk("fs_per_frame", fs_cnt - fs0, 1);
    chk("last_x", 32'(last_x), EXP_HA - 1);
    chk("last_y", 32'(last_y), EXP_VA - 1);
    chk("last_data", 32'(last_data), EXP_LAST);
    chk("first_data", 32'(fs_data), EXP_FIRST);
    chk("fs_at_origin_bad", fs_bad, 0);
    chk("no_err_clean", err_cnt, 0);
`ifdef FRAME_CHKSUM_EN
    chk("frame_sum", bus.frame_sum, 32'd120636);
`endif

    // One 21-clock line inside a locked frame
    run_frame(5);
    chk("stretch_no_err_yet", err_cnt, 0);
    run_frame(-1);
    chk("stretch_err", err_cnt, 1);
    chk("stretch_unlock", 32'(bus.locked), 0);
    run_frame(-1);
    chk("stretch_relock", 32'(bus.locked), 1);
    chk("stretch_h_total", 32'(bus.h_total), EXP_HT);

    // HS stuck inactive
    err0       = err_cnt;
    hold_start = cyc;
    hold_idle(5000);
    chk("timeout_err_once", err_cnt - err0, 1);
    chk("timeout_window", 32'((err_cyc - hold_start >= 4060) && (err_cyc - hold_start <= 4100)), 1);
    chk("timeout_unlock", 32'(bus.locked), 0);
    chk("timeout_keeps_h_total", 32'(bus.h_total), EXP_HT);

    // Relock, then reset in the middle of an active line
    run_frame(-1);
    run_frame(-1);
    for (int l = 0; l < 5; l++) run_line(l, 0, int'(LINE_CLKS));
    run_line(5, 0, 12);
    chk("pre_rst_locked", 32'(bus.locked), 1);
    chk("pre_rst_pix_x", 32'(bus.pix_x), 4);
    chk("pre_rst_pix_y", 32'(bus.pix_y), 1);
    rst_n = 1'b0;
    run_line(5, 12, 15);
    chk("mid_rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("mid_rst_pix_x", 32'(bus.pix_x), 0);
    chk("mid_rst_pix_y", 32'(bus.pix_y), 0);
    chk("mid_rst_pix_data", 32'(bus.pix_data), 0);
    chk("mid_rst_h_total", 32'(bus.h_total), 0);
    chk("mid_rst_v_active", 32'(bus.v_active), 0);
    chk("mid_rst_locked", 32'(bus.locked), 0);
    rst_n = 1'b1;
    run_line(5, 15, int'(LINE_CLKS));
    for (int l = 6; l < int'(FRM_LINES); l++) run_line(l, 0, int'(LINE_CLKS));
    run_frame(-1);
    run_frame(-1);
    chk("post_rst_not_locked", 32'(bus.locked), 0);
    run_frame(-1);
    chk("post_rst_relock", 32'(bus.locked), 1);
    chk("post_rst_v_total", 32'(bus.v_total), EXP_VT);
    chk("pixel_latency_bad", lat_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
